// File: rtl/parity_mem_pkg.sv
// Shared types and helpers for the parity-protected memory.
// lane_parity works on a maximum-width word, and the caller truncates the result to its own lane count.
package parity_mem_pkg;

  typedef enum logic {INIT, IDLE} state_t;

  localparam int ERR_CNT_W  = 16;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_LANES  = 32;

  // Lane 0 lands in bit 0 because lanes are shifted in from the top lane down.
  function automatic logic [MAX_LANES-1:0] lane_parity(
    input logic [MAX_DATA_W-1:0] data,
    input logic                  odd,
    input int                    byte_w,
    input int                    nlanes
  );
    logic [MAX_LANES-1:0]  p;
    logic [MAX_DATA_W-1:0] sh;
    logic                  par;
    p = '0;
    for (int i = nlanes - 1; i >= 0; i--) begin
      sh  = data >> (i * byte_w);
      par = odd;
      for (int b = 0; b < byte_w; b++) begin
        par = par ^ sh[0];
        sh  = sh >> 1;
      end
      p = {p[MAX_LANES-2:0], par};
    end
    return p;
  endfunction

endpackage

// File: rtl/parity_mem_rd_pipe.sv
// Read-side pipeline: parity check, RD_LAT output stages, and a saturating error counter.
// data_out and parity_err hold their last values between reads.
module parity_mem_rd_pipe
  import parity_mem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NLANES     = 2,
  parameter int RD_LAT     = 1,
  parameter int BYTE_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_rd_en,
  input  logic [DATA_W+NLANES-1:0] i_rd_word,
  input  logic                     i_cnt_clr,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_rd_valid,
  output logic [NLANES-1:0]        o_parity_err,
  output logic [ERR_CNT_W-1:0]     o_err_count
);

  logic [DATA_W-1:0]    w_data;
  logic [NLANES-1:0]    w_chk;
  logic                 r_s1_valid;
  logic [DATA_W-1:0]    r_s1_data;
  logic [NLANES-1:0]    r_s1_err;
  logic                 w_out_valid;
  logic [DATA_W-1:0]    w_out_data;
  logic [NLANES-1:0]    w_out_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_data = i_rd_word[DATA_W-1:0];
  assign w_chk  = NLANES'(lane_parity(MAX_DATA_W'(w_data), 1'(PARITY_ODD), BYTE_W, NLANES))
                  ^ i_rd_word[DATA_W +: NLANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_err   <= '0;
    end else begin
      r_s1_valid <= i_rd_en;
      if (i_rd_en) begin
        r_s1_data <= w_data;
        r_s1_err  <= w_chk;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_s2_valid;
      logic [DATA_W-1:0] r_s2_data;
      logic [NLANES-1:0] r_s2_err;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
          r_s2_err   <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
            r_s2_err  <= r_s1_err;
          end
        end
      end

      assign w_out_valid = r_s2_valid;
      assign w_out_data  = r_s2_data;
      assign w_out_err   = r_s2_err;
    end else begin : g_lat1
      assign w_out_valid = r_s1_valid;
      assign w_out_data  = r_s1_data;
      assign w_out_err   = r_s1_err;
    end
  endgenerate

  // A clear wins over an increment that arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (i_cnt_clr) begin
      r_err_count <= '0;
    end else if (w_out_valid && (|w_out_err) && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign o_data       = w_out_data;
  assign o_rd_valid   = w_out_valid;
  assign o_parity_err = w_out_err;
  assign o_err_count  = r_err_count;

endmodule

// File: rtl/parity_mem.sv
// Parity-protected single-port memory: storage array, init-sweep FSM and write path.
// The read pipeline and error counter live in parity_mem_rd_pipe.
module parity_mem
  import parity_mem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int BYTE_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LAT     = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_write,
  input  logic                       i_read,
  input  logic [ADDR_W-1:0]          i_address,
  input  logic [DATA_W-1:0]          i_data_in,
  input  logic                       i_err_inj,
  input  logic                       i_init_req,
  output logic                       o_ready,
  output logic [DATA_W-1:0]          o_data_out,
  output logic                       o_rd_valid,
  output logic [DATA_W/BYTE_W-1:0]   o_parity_err,
  output logic [ERR_CNT_W-1:0]       o_err_count
);

  localparam int NLANES = DATA_W / BYTE_W;
  localparam int MEM_W  = DATA_W + NLANES;

  logic [MEM_W-1:0]  r_mem [0:DEPTH-1];
  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_ready;

  logic              w_idle;
  logic              w_in_range;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_cnt_clr;
  logic [NLANES-1:0] w_zero_par;
  logic [NLANES-1:0] w_wr_par;
  logic [MEM_W-1:0]  w_rd_word;

  assign w_idle     = (r_state == IDLE);
  assign w_in_range = ({1'b0, i_address} < (ADDR_W + 1)'(DEPTH));
  assign w_wr_en    = w_idle && i_write && w_in_range;
  assign w_rd_en    = w_idle && i_read && !i_write;
  assign w_cnt_clr  = w_idle && i_init_req;
  assign w_zero_par = NLANES'(lane_parity('0, 1'(PARITY_ODD), BYTE_W, NLANES));
  assign w_wr_par   = NLANES'(lane_parity(MAX_DATA_W'(i_data_in), 1'(PARITY_ODD), BYTE_W, NLANES))
                      ^ NLANES'(i_err_inj);

  // Out-of-range reads see zero data carrying correct parity, so they never flag an error.
  assign w_rd_word  = w_in_range ? r_mem[i_address] : {w_zero_par, {DATA_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_ptr] <= {w_zero_par, {DATA_W{1'b0}}};
    end else if (w_wr_en) begin
      r_mem[i_address] <= {w_wr_par, i_data_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_ptr   <= '0;
          end
        end
        IDLE: begin
          if (i_init_req) begin
            r_state <= INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= INIT;
          r_ptr   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_ready;

  parity_mem_rd_pipe #(
    .DATA_W     (DATA_W),
    .NLANES     (NLANES),
    .RD_LAT     (RD_LAT),
    .BYTE_W     (BYTE_W),
    .PARITY_ODD (PARITY_ODD)
  ) u_rd_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rd_en      (w_rd_en),
    .i_rd_word    (w_rd_word),
    .i_cnt_clr    (w_cnt_clr),
    .o_data       (o_data_out),
    .o_rd_valid   (o_rd_valid),
    .o_parity_err (o_parity_err),
    .o_err_count  (o_err_count)
  );

endmodule

// File: tb/tb_parity_mem.sv
// Bench for parity_mem: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream.
// An abstract model predicts both instances every cycle, and directed literals pin the key points.
module tb_parity_mem;

  localparam int DEP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0, rd = 1'b0, inj = 1'b0, ireq = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] din = '0;

  logic        rdy  [2];
  logic [15:0] dout [2];
  logic        vld  [2];
  logic [1:0]  perr [2];
  logic [15:0] cnt  [2];

  always #5 clk = ~clk;

  parity_mem #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .PARITY_ODD(0)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .i_write(wr), .i_read(rd), .i_address(addr), .i_data_in(din),
    .i_err_inj(inj), .i_init_req(ireq), .o_ready(rdy[0]), .o_data_out(dout[0]),
    .o_rd_valid(vld[0]), .o_parity_err(perr[0]), .o_err_count(cnt[0]));

  parity_mem #(.DATA_W(16), .BYTE_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(2), .PARITY_ODD(0)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .i_write(wr), .i_read(rd), .i_address(addr), .i_data_in(din),
    .i_err_inj(inj), .i_init_req(ireq), .o_ready(rdy[1]), .o_data_out(dout[1]),
    .o_rd_valid(vld[1]), .o_parity_err(perr[1]), .o_err_count(cnt[1]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: words plus an "injected" flag per word. A read of an injected word reports lane 0 in error.
  logic [15:0] m_mem [DEP];
  logic        m_inj [DEP];
  int          m_busy;
  int          m_cyc;
  logic        h_v [4];
  logic [15:0] h_d [4];
  logic [1:0]  h_e [4];
  logic        e_v [2];
  logic [15:0] e_d [2];
  logic [1:0]  e_e [2];
  int          e_cnt [2];

  task automatic m_reset();
    m_busy = DEP;
    m_cyc  = 0;
    for (int i = 0; i < DEP; i++) begin
      m_mem[i] = '0;
      m_inj[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      h_v[i] = 1'b0; h_d[i] = '0; h_e[i] = '0;
    end
    for (int l = 0; l < 2; l++) begin
      e_v[l] = 1'b0; e_d[l] = '0; e_e[l] = '0; e_cnt[l] = 0;
    end
  endtask

  task automatic m_step();
    logic        acc, clr;
    logic [15:0] ad;
    logic [1:0]  ae;
    int          slot, s;
    if (!rst_n) begin
      m_reset();
      return;
    end
    acc = 1'b0; clr = 1'b0; ad = '0; ae = '0;
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      if (rd && !wr) begin
        acc = 1'b1;
        ad  = m_mem[addr];
        ae  = m_inj[addr] ? 2'b01 : 2'b00;
      end
      if (wr) begin
        m_mem[addr] = din;
        m_inj[addr] = inj;
      end
      if (ireq) begin
        clr    = 1'b1;
        m_busy = DEP;
        for (int i = 0; i < DEP; i++) begin
          m_mem[i] = '0;
          m_inj[i] = 1'b0;
        end
      end
    end
    slot = m_cyc % 4;
    h_v[slot] = acc; h_d[slot] = ad; h_e[slot] = ae;
    for (int l = 0; l < 2; l++) begin
      if (clr) e_cnt[l] = 0;
      else if (e_v[l] && e_e[l] != 2'b00 && e_cnt[l] < 65535) e_cnt[l]++;
      s = (m_cyc - l + 4) % 4;
      e_v[l] = h_v[s];
      if (h_v[s]) begin
        e_d[l] = h_d[s];
        e_e[l] = h_e[s];
      end
    end
    m_cyc++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      m_step();
      @(negedge clk);
      if (!rst_n) m_reset();
      for (int l = 0; l < 2; l++) begin
        check($sformatf("lat%0d_ready", l + 1), 32'(rdy[l]), 32'(m_busy == 0));
        check($sformatf("lat%0d_rd_valid", l + 1), 32'(vld[l]), 32'(e_v[l]));
        check($sformatf("lat%0d_data_out", l + 1), 32'(dout[l]), 32'(e_d[l]));
        check($sformatf("lat%0d_parity_err", l + 1), 32'(perr[l]), 32'(e_e[l]));
        check($sformatf("lat%0d_err_count", l + 1), 32'(cnt[l]), 32'(e_cnt[l]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_op(input logic [3:0] a, input logic [15:0] d, input logic e);
    addr = a; din = d; inj = e; wr = 1'b1;
    tick();
    wr = 1'b0; inj = 1'b0;
    $display("write addr=%0d data=%h err_inj=%0b", a, d, e);
  endtask

  task automatic rd_op(input logic [3:0] a);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    $display("read  addr=%0d lat1 data=%h perr=%b", a, dout[0], perr[0]);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < DEP; i++) begin
      check({tag, "_ready_low"}, 32'(rdy[0]), 32'd0);
      tick();
    end
    check({tag, "_ready_high"}, 32'(rdy[0]), 32'd1);
    check({tag, "_ready_high_l2"}, 32'(rdy[1]), 32'd1);
  endtask

  initial begin
    // 1: reset release, init sweep, read a swept word
    repeat (2) tick();
    rst_n = 1'b1;
    wait_init("s1");
    rd_op(4'd5);
    check("s1_valid", 32'(vld[0]), 32'd1);
    check("s1_data", 32'(dout[0]), 32'h0000);
    check("s1_perr", 32'(perr[0]), 32'd0);
    check("s1_l2_not_yet", 32'(vld[1]), 32'd0);
    tick();
    check("s1_l2_valid", 32'(vld[1]), 32'd1);

    // 2: plain write then read
    wr_op(4'd3, 16'hA5C3, 1'b0);
    rd_op(4'd3);
    check("s2_data", 32'(dout[0]), 32'hA5C3);
    check("s2_perr", 32'(perr[0]), 32'd0);
    check("s2_cnt", 32'(cnt[0]), 32'd0);
    tick();

    // 3: injected lane-0 parity error, read twice
    wr_op(4'd7, 16'h0101, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      rd_op(4'd7);
      check("s3_perr", 32'(perr[0]), 32'h1);
      tick();
      check("s3_cnt", 32'(cnt[0]), 32'(k));
      check("s3_l2_valid", 32'(vld[1]), 32'd1);
      check("s3_l2_perr", 32'(perr[1]), 32'h1);
      tick();
      check("s3_l2_cnt", 32'(cnt[1]), 32'(k));
    end

    // 4: write and read together, the read is dropped
    addr = 4'd2; din = 16'h1234; wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("s4_no_valid", 32'(vld[0]), 32'd0);
    tick();
    check("s4_l2_no_valid", 32'(vld[1]), 32'd0);
    rd_op(4'd2);
    check("s4_data", 32'(dout[0]), 32'h1234);

    // back-to-back reads
    addr = 4'd3; rd = 1'b1;
    tick();
    check("b2b_first", 32'(dout[0]), 32'hA5C3);
    addr = 4'd2;
    tick();
    rd = 1'b0;
    check("b2b_second", 32'(dout[0]), 32'h1234);
    check("b2b_l2_first", 32'(dout[1]), 32'hA5C3);
    tick();
    check("b2b_l2_second", 32'(dout[1]), 32'h1234);

    // 5: init_req together with a read; the read still completes
    addr = 4'd3; rd = 1'b1; ireq = 1'b1;
    tick();
    rd = 1'b0; ireq = 1'b0;
    check("s5_rd_valid", 32'(vld[0]), 32'd1);
    check("s5_rd_data", 32'(dout[0]), 32'hA5C3);
    check("s5_cnt_clr", 32'(cnt[0]), 32'd0);
    check("s5_l2_cnt_clr", 32'(cnt[1]), 32'd0);
    wait_init("s5");
    rd_op(4'd7);
    check("s5_data", 32'(dout[0]), 32'h0000);
    check("s5_perr", 32'(perr[0]), 32'd0);
    tick();

    // 6: asynchronous reset in the middle of an init sweep
    wr_op(4'd7, 16'h0101, 1'b1);
    rd_op(4'd7);
    repeat (2) tick();
    check("s6_pre_data", 32'(dout[1]), 32'h0101);
    ireq = 1'b1;
    tick();
    ireq = 1'b0;
    repeat (4) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      check("s6_ready", 32'(rdy[l]), 32'd0);
      check("s6_data", 32'(dout[l]), 32'd0);
      check("s6_valid", 32'(vld[l]), 32'd0);
      check("s6_perr", 32'(perr[l]), 32'd0);
      check("s6_cnt", 32'(cnt[l]), 32'd0);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    wait_init("s6");

    // extra directed traffic; the model checks every cycle
    wr_op(4'd0, 16'hFFFF, 1'b0);
    wr_op(4'd15, 16'h8001, 1'b1);
    wr_op(4'd9, 16'h00FF, 1'b0);
    addr = 4'd0; rd = 1'b1;
    tick();
    addr = 4'd15;
    tick();
    addr = 4'd9;
    tick();
    addr = 4'd15;
    tick();
    rd = 1'b0;
    check("x_last_perr", 32'(perr[0]), 32'h1);
    repeat (3) tick();
    check("x_cnt", 32'(cnt[0]), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
